tt_pad_ctrl: RTL and testbench
==============================

TT_PAD_CTRL -- requirements
Module: tt_pad_ctrl

Interface
REQ-001 SHALL have parameter QUIESCE_CYC, default 2, cycles the target pad's OE is held low before a config change (legal 1..15).
REQ-002 SHALL have parameter SETTLE_CYC, default 4, cycles the target pad's OE is held low after a config change (legal 1..15).
REQ-003 SHALL have port clk, input, 1, sole clock; all flops rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port uio_out, input, 16, user design pad output data.
REQ-006 SHALL have port uio_oe, input, 16, user design per-pad output enable.
REQ-007 SHALL have port uio_in, output, 16, synchronised pad input data to the user design.
REQ-008 SHALL have port tt_bi_Y, input, 16, raw pad input value from the pad ring macro.
REQ-009 SHALL have ports tt_bi_A, tt_bi_OE, tt_bi_IE, tt_bi_SL, tt_bi_CS, tt_bi_PD, tt_bi_PU, output, 16 each, pad controls to the pad ring macro.
REQ-010 SHALL have port cfg_valid, input, 1, config write request.
REQ-011 SHALL have port cfg_ready, output, 1, config write can be accepted.
REQ-012 SHALL have port cfg_addr, input, 4, target pad index.
REQ-013 SHALL have port cfg_data, input, 6, config word: [5] OE_EN, [4] IE, [3] SL, [2] CS, [1] PD, [0] PU.
REQ-014 SHALL have port cfg_rd_addr, input, 4, readback pad index.
REQ-015 SHALL have port cfg_rd_data, output, 6, combinational readback of the stored config word for cfg_rd_addr.
REQ-016 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-017 SHALL hold one 6-bit config register per pad; tt_bi_IE/SL/CS/PD/PU[i] SHALL be driven directly from bits [4:0] of pad i's register.
REQ-018 SHALL register tt_bi_A (tt_bi_A <= uio_out), giving 1 cycle of latency.
REQ-019 SHALL register tt_bi_OE[i] <= uio_oe[i] & OE_EN[i] & ~mask[i].
REQ-020 SHALL assert mask[i] when pad i is the target of a write being accepted this cycle, or when the FSM is not IDLE and the latched target equals i.
REQ-021 SHALL pass tt_bi_Y through a two-flop synchroniser per bit to uio_in, giving 2 cycles of latency with no combinational path.
REQ-022 SHALL implement FSM states IDLE, QUIESCE, APPLY and SETTLE; cfg_ready SHALL equal (state==IDLE) and busy SHALL equal ~cfg_ready.
REQ-023 SHALL accept a write on a clock edge where cfg_valid & cfg_ready, latching cfg_addr and cfg_data and moving IDLE->QUIESCE.
REQ-024 SHALL hold QUIESCE for exactly QUIESCE_CYC cycles and then move to APPLY, using a 4-bit down-counter.
REQ-025 SHALL hold APPLY for exactly 1 cycle; the latched data SHALL be written to the target register on the edge leaving APPLY, and the FSM SHALL move to SETTLE.
REQ-026 SHALL hold SETTLE for exactly SETTLE_CYC cycles and then move to IDLE.
REQ-027 SHALL keep cfg_ready low for QUIESCE_CYC+1+SETTLE_CYC cycles after each accept.
REQ-028 SHALL ignore cfg_valid while not IDLE; the request SHALL NOT be queued, and the master must hold it.
REQ-029 SHALL run the full sequence when a write carries data identical to the stored word.
REQ-030 SHALL leave non-target pads' outputs unaffected by any write sequence.
REQ-031 SHALL return the old word on cfg_rd_data for the target pad until the APPLY edge, and the new word afterwards.

Reset
REQ-032 SHALL, on rst_n low, immediately and asynchronously force: every config register = 6'b010000 (IE=1, all else 0); FSM=IDLE; counter=0; tt_bi_A=0; tt_bi_OE=0; synchroniser flops and uio_in=0; cfg_ready=1; busy=0.
REQ-033 SHALL, when reset is asserted mid-sequence, abandon the pending write so the target config stays at its reset default.
REQ-034 SHALL accept the first write on the first clock edge after rst_n deasserts, given cfg_valid=1.

Verification
REQ-035 Reset: pulse rst_n low -> all tt_bi_IE=16'hFFFF, tt_bi_OE/PU/PD/SL/CS=0, cfg_ready=1, cfg_rd_data=6'h10 for every address.
REQ-036 Write timing: defaults; accept write pad 3 = 6'h21 at edge E0 -> cfg_ready low for 7 cycles; tt_bi_PU[3]=1 after E3; tt_bi_OE[3] stays 0 through E7; with uio_oe[3]=1, tt_bi_OE[3]=1 after E8.
REQ-037 OE masking: pad 5 configured OE_EN=1 and driving; write pad 5 -> tt_bi_OE[5]=0 from E0+1 through E7; tt_bi_OE of other pads unchanged throughout.
REQ-038 Busy: assert cfg_valid to pad 7 during SETTLE of a pad-3 write -> pad 7 is not accepted until cfg_ready returns; pad 7 then completes its own 7-cycle sequence.
REQ-039 Synchroniser: toggle tt_bi_Y[0] -> uio_in[0] follows exactly 2 edges later; tt_bi_A mirrors uio_out 1 edge later.
REQ-040 Reset mid-sequence: assert rst_n during QUIESCE of a pad-2 write of 6'h3F -> pad 2 reads 6'h10 after reset; tt_bi_OE[2]=0.

Source files
------------

// File: rtl/tt_pad_ctrl.sv
// Pad-ring controller: registers user pad outputs, synchronises pad inputs, and
// sequences per-pad config writes with the target's output enable held off around the change.
module tt_pad_ctrl #(
   parameter int QUIESCE_CYC = 2,
   parameter int SETTLE_CYC  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] uio_out,
   input  logic [15:0] uio_oe,
   output logic [15:0] uio_in,
   input  logic [15:0] tt_bi_Y,
   output logic [15:0] tt_bi_A,
   output logic [15:0] tt_bi_OE,
   output logic [15:0] tt_bi_IE,
   output logic [15:0] tt_bi_SL,
   output logic [15:0] tt_bi_CS,
   output logic [15:0] tt_bi_PD,
   output logic [15:0] tt_bi_PU,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [3:0]  cfg_addr,
   input  logic [5:0]  cfg_data,
   input  logic [3:0]  cfg_rd_addr,
   output logic [5:0]  cfg_rd_data,
   output logic        busy
);

   // state   | meaning
   // IDLE    | ready for a config write
   // QUIESCE | target OE forced low, waiting before the change
   // APPLY   | latched word written to the target register on exit
   // SETTLE  | target OE still forced low while the pad settles

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUIESCE = 2'd1,
      APPLY   = 2'd2,
      SETTLE  = 2'd3
   } state_t;

   localparam logic [3:0] QUIESCE_LOAD = 4'(QUIESCE_CYC - 1);
   localparam logic [3:0] SETTLE_LOAD  = 4'(SETTLE_CYC - 1);
   localparam logic [5:0] CFG_RST      = 6'b010000;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt;
   logic [3:0]        cnt_nxt;
   logic              accept;
   logic              apply_wr;
   logic [3:0]        tgt_addr;
   logic [5:0]        tgt_data;
   logic [15:0][5:0]  cfg_q;
   logic [15:0]       oe_en;
   logic [15:0]       mask;
   logic [15:0]       sync_q1;
   logic [15:0]       sync_q2;

   assign cfg_ready = (state == IDLE);
   assign busy      = ~cfg_ready;
   assign accept    = cfg_valid & cfg_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Counters load N-1 so each timed state lasts exactly N cycles.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      apply_wr  = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_valid) begin
               state_nxt = QUIESCE;
               cnt_nxt   = QUIESCE_LOAD;
            end
         end
         QUIESCE: begin
            if (cnt == 4'd0) begin
               state_nxt = APPLY;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         APPLY: begin
            apply_wr  = 1'b1;
            state_nxt = SETTLE;
            cnt_nxt   = SETTLE_LOAD;
         end
         SETTLE: begin
            if (cnt == 4'd0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_addr <= 4'd0;
         tgt_data <= 6'd0;
      end else if (accept) begin
         tgt_addr <= cfg_addr;
         tgt_data <= cfg_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            cfg_q[i] <= CFG_RST;
         end
      end else if (apply_wr) begin
         cfg_q[tgt_addr] <= tgt_data;
      end
   end

   assign cfg_rd_data = cfg_q[cfg_rd_addr];

   always_comb begin
      tt_bi_IE = '0;
      tt_bi_SL = '0;
      tt_bi_CS = '0;
      tt_bi_PD = '0;
      tt_bi_PU = '0;
      oe_en    = '0;
      for (int i = 0; i < 16; i++) begin
         oe_en[i]    = cfg_q[i][5];
         tt_bi_IE[i] = cfg_q[i][4];
         tt_bi_SL[i] = cfg_q[i][3];
         tt_bi_CS[i] = cfg_q[i][2];
         tt_bi_PD[i] = cfg_q[i][1];
         tt_bi_PU[i] = cfg_q[i][0];
      end
   end

   // Mask covers the accept edge too, so the target OE drops on the very next cycle.
   always_comb begin
      mask = '0;
      if (accept) begin
         mask[cfg_addr] = 1'b1;
      end
      if (state != IDLE) begin
         mask[tgt_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt_bi_A  <= '0;
         tt_bi_OE <= '0;
      end else begin
         tt_bi_A  <= uio_out;
         tt_bi_OE <= uio_oe & oe_en & ~mask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= tt_bi_Y;
         sync_q2 <= sync_q1;
      end
   end

   assign uio_in = sync_q2;

endmodule

// File: tb/tb_tt_pad_ctrl.sv
// Self-checking bench for tt_pad_ctrl: write sequencing, OE masking, busy handling,
// reset behaviour and a queue scoreboard for the pad data paths.
module tb_tt_pad_ctrl;

   localparam int Q       = 2;
   localparam int S       = 4;
   localparam int TOT     = Q + 1 + S;
   localparam int APPLY_K = Q + 1;

   logic        clk;
   logic        rst_n;
   logic [15:0] uio_out;
   logic [15:0] uio_oe;
   logic [15:0] uio_in;
   logic [15:0] tt_bi_Y;
   logic [15:0] tt_bi_A;
   logic [15:0] tt_bi_OE;
   logic [15:0] tt_bi_IE;
   logic [15:0] tt_bi_SL;
   logic [15:0] tt_bi_CS;
   logic [15:0] tt_bi_PD;
   logic [15:0] tt_bi_PU;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [3:0]  cfg_addr;
   logic [5:0]  cfg_data;
   logic [3:0]  cfg_rd_addr;
   logic [5:0]  cfg_rd_data;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [5:0]  exp_cfg [16];
   logic [15:0] a_q [$];
   logic [15:0] y_q [$];
   logic [15:0] oe_q [$];

   tt_pad_ctrl #(.QUIESCE_CYC(Q), .SETTLE_CYC(S)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .uio_out     (uio_out),
      .uio_oe      (uio_oe),
      .uio_in      (uio_in),
      .tt_bi_Y     (tt_bi_Y),
      .tt_bi_A     (tt_bi_A),
      .tt_bi_OE    (tt_bi_OE),
      .tt_bi_IE    (tt_bi_IE),
      .tt_bi_SL    (tt_bi_SL),
      .tt_bi_CS    (tt_bi_CS),
      .tt_bi_PD    (tt_bi_PD),
      .tt_bi_PU    (tt_bi_PU),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .cfg_rd_addr (cfg_rd_addr),
      .cfg_rd_data (cfg_rd_data),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) exp_cfg[i] = 6'h10;
   endtask

   function automatic logic [15:0] model_bit(input int b);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[i] = exp_cfg[i][b];
      return r;
   endfunction

   function automatic logic [15:0] model_oe(input logic [15:0] m);
      return model_bit(5) & uio_oe & ~m;
   endfunction

   // Drives a write and checks every cycle until one cycle past the return to idle.
   task automatic write_seq(input logic [3:0] a, input logic [5:0] d);
      logic [5:0]  old_w;
      logic [15:0] tmask;
      old_w       = exp_cfg[a];
      tmask       = 16'h0001 << a;
      cfg_addr    = a;
      cfg_data    = d;
      cfg_valid   = 1'b1;
      cfg_rd_addr = a;
      tick();
      cfg_valid = 1'b0;
      cfg_data  = ~d;
      chk("acc_ready", 32'(cfg_ready), 32'd0);
      chk("acc_oe", 32'(tt_bi_OE), 32'(model_oe(tmask)));
      for (int k = 1; k <= TOT + 1; k++) begin
         tick();
         if (k == APPLY_K) exp_cfg[a] = d;
         chk("wr_ready", 32'(cfg_ready), 32'(k >= TOT));
         chk("wr_busy", 32'(busy), 32'(k < TOT));
         chk("wr_rd", 32'(cfg_rd_data), 32'((k >= APPLY_K) ? d : old_w));
         chk("wr_pu", 32'(tt_bi_PU), 32'(model_bit(0)));
         chk("wr_ie", 32'(tt_bi_IE), 32'(model_bit(4)));
         chk("wr_oe", 32'(tt_bi_OE), 32'(model_oe((k <= TOT) ? tmask : 16'h0)));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] old7;
      rst_n       = 1'b0;
      uio_out     = '0;
      uio_oe      = 16'hFFFF;
      tt_bi_Y     = '0;
      cfg_valid   = 1'b0;
      cfg_addr    = '0;
      cfg_data    = '0;
      cfg_rd_addr = '0;
      model_reset();

      #12;
      chk("rst_ie", 32'(tt_bi_IE), 32'hFFFF);
      chk("rst_oe", 32'(tt_bi_OE), 32'h0);
      chk("rst_pu", 32'(tt_bi_PU), 32'h0);
      chk("rst_pd", 32'(tt_bi_PD), 32'h0);
      chk("rst_sl", 32'(tt_bi_SL), 32'h0);
      chk("rst_cs", 32'(tt_bi_CS), 32'h0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_uio_in", 32'(uio_in), 32'h0);
      chk("rst_a", 32'(tt_bi_A), 32'h0);
      for (int i = 0; i < 16; i++) begin
         cfg_rd_addr = 4'(i);
         #1;
         chk("rst_rd", 32'(cfg_rd_data), 32'h10);
      end

      // First write lands on the very first edge after reset release.
      tick();
      rst_n = 1'b1;
      write_seq(4'd3, 6'h21);

      // Data-path scoreboard with random pad traffic.
      for (int i = 0; i < 40; i++) begin
         uio_out = 16'($urandom);
         tt_bi_Y = 16'($urandom);
         uio_oe  = 16'($urandom);
         a_q.push_back(uio_out);
         y_q.push_back(tt_bi_Y);
         oe_q.push_back(uio_oe & model_bit(5));
         tick();
         chk("sb_a", 32'(tt_bi_A), 32'(a_q.pop_front()));
         chk("sb_oe", 32'(tt_bi_OE), 32'(oe_q.pop_front()));
         if (y_q.size() == 2) chk("sb_y", 32'(uio_in), 32'(y_q.pop_front()));
      end
      uio_oe = 16'hFFFF;
      tick();

      // Pad 5 driving, then rewritten while pad 3 keeps driving.
      write_seq(4'd5, 6'h30);
      write_seq(4'd5, 6'h31);
      // Identical data still runs the whole sequence.
      write_seq(4'd5, 6'h31);

      // Pad 7 requested during pad 3's settle phase must wait.
      old7        = exp_cfg[7];
      cfg_addr    = 4'd3;
      cfg_data    = 6'h25;
      cfg_valid   = 1'b1;
      cfg_rd_addr = 4'd7;
      tick();
      cfg_valid = 1'b0;
      for (int k = 1; k <= TOT; k++) begin
         tick();
         if (k == APPLY_K) exp_cfg[3] = 6'h25;
         chk("bz_ready", 32'(cfg_ready), 32'(k >= TOT));
         chk("bz_rd7", 32'(cfg_rd_data), 32'(old7));
         chk("bz_oe", 32'(tt_bi_OE), 32'(model_oe(16'h0008)));
         if (k == Q + 2) begin
            cfg_addr  = 4'd7;
            cfg_data  = 6'h3A;
            cfg_valid = 1'b1;
         end
      end
      cfg_rd_addr = 4'd3;
      #1;
      chk("bz_rd3", 32'(cfg_rd_data), 32'h25);
      write_seq(4'd7, 6'h3A);

      // Reset during QUIESCE abandons the pending write.
      cfg_addr    = 4'd2;
      cfg_data    = 6'h3F;
      cfg_valid   = 1'b1;
      cfg_rd_addr = 4'd2;
      tick();
      cfg_valid = 1'b0;
      tick();
      chk("mr_busy_pre", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mr_rd2", 32'(cfg_rd_data), 32'h10);
      chk("mr_oe", 32'(tt_bi_OE), 32'h0);
      chk("mr_ready", 32'(cfg_ready), 32'd1);
      chk("mr_uio_in", 32'(uio_in), 32'h0);
      chk("mr_a", 32'(tt_bi_A), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < TOT + 2; k++) tick();
      chk("mr_rd2_post", 32'(cfg_rd_data), 32'h10);
      chk("mr_oe_post", 32'(tt_bi_OE), 32'(model_oe(16'h0)));
      chk("mr_oe2_post", 32'(tt_bi_OE[2]), 32'd0);
      chk("mr_ready_post", 32'(cfg_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
